// File: rtl/adder_share_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// adder_share_arbiter_pkg
// Shared constants and helpers for the shared-adder arbiter slice.
//   ADDER_W    : default operand / sum width
//   ADDER_NREQ : default number of requesters sharing the adder
//   clog2()    : ceiling log2, used to size requester IDs
// ---------------------------------------------------------------------------
package adder_share_arbiter_pkg;

  localparam int ADDER_W    = 32;
  localparam int ADDER_NREQ = 4;

  // Smallest r with 2**r >= value; written as a bounded loop so it folds
  // to a constant during elaboration.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/adder_share_arbiter_adder.sv
// ---------------------------------------------------------------------------
// ripple_carry_adder
// Combinational WIDTH-bit ripple-carry adder. The carry out of the top bit is
// not exported; callers that want modular arithmetic simply ignore it.
//   a, b : operands
//   cin  : carry into bit 0
//   sum  : (a + b + cin) mod 2**WIDTH
// ---------------------------------------------------------------------------
module ripple_carry_adder
  import adder_share_arbiter_pkg::*;
#(
  parameter int WIDTH = ADDER_W
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum
);

  logic w_carry;

  // Bit-serial carry chain; w_carry always holds the carry into the bit
  // currently being summed.
  always_comb begin
    sum     = '0;
    w_carry = cin;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i]  = a[i] ^ b[i] ^ w_carry;
      w_carry = (a[i] & b[i]) | (w_carry & (a[i] ^ b[i]));
    end
  end

endmodule

// File: rtl/adder_share_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter. Grants the first asserted request at or after the
// pointer, wrapping around; the pointer moves past the winner only when a
// grant is actually issued, so idle cycles do not rotate priority.
//   clk, rst  : clock, async active-high reset
//   req       : per-requester request vector
//   en        : grant enable (0 forces grant to zero and freezes pointer)
//   grant     : one-hot-or-zero grant
//   grant_idx : index of the winning requester (0 when nothing requests)
// ---------------------------------------------------------------------------
module rr_arbiter
  import adder_share_arbiter_pkg::*;
#(
  parameter int N_REQ = ADDER_NREQ,
  parameter int ID_W  = clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             en,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_idx
);

  logic [ID_W-1:0]  r_ptr;
  logic [N_REQ-1:0] w_pick;
  logic             w_found;

  // Two passes avoid modular index arithmetic: first the requesters at or
  // above the pointer, then the ones below it (the wrapped part).
  always_comb begin
    w_pick    = '0;
    w_found   = 1'b0;
    grant_idx = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (!w_found && req[j] && (ID_W'(j) >= r_ptr)) begin
        w_found   = 1'b1;
        w_pick[j] = 1'b1;
        grant_idx = ID_W'(j);
      end
    end
    for (int j = 0; j < N_REQ; j++) begin
      if (!w_found && req[j] && (ID_W'(j) < r_ptr)) begin
        w_found   = 1'b1;
        w_pick[j] = 1'b1;
        grant_idx = ID_W'(j);
      end
    end
    grant = en ? w_pick : '0;
  end

  // Pointer lands just after the winner so it becomes lowest priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (en && w_found) begin
      r_ptr <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
    end
  end

endmodule

// File: rtl/adder_share_arbiter.sv
// ---------------------------------------------------------------------------
// adder_share_arbiter
// Shares one ripple-carry adder among N_REQ requesters. A round-robin
// arbiter picks one requester per cycle, its operands are added, and the
// sum is captured with the requester ID and signed-overflow flag into a
// single output register with a valid/ready handshake.
//   clk, rst   : clock, async active-high reset
//   req_valid  : per-requester request
//   req_a/b    : flattened operands, requester i owns [i*WIDTH +: WIDTH]
//   req_ready  : one-hot-or-zero grant (transfer = req_valid & req_ready)
//   rsp_valid  : result register holds a valid sum
//   rsp_ready  : consumer accepts the result
//   rsp_id     : requester that produced rsp_sum
//   rsp_sum    : (a + b) mod 2**WIDTH
//   rsp_ovf    : two's-complement overflow of the granted addition
// ---------------------------------------------------------------------------
module adder_share_arbiter
  import adder_share_arbiter_pkg::*;
#(
  parameter int N_REQ = ADDER_NREQ,
  parameter int WIDTH = ADDER_W,
  parameter int ID_W  = clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [WIDTH-1:0]       rsp_sum,
  output logic                   rsp_ovf
);

  logic             r_rspValid;
  logic [ID_W-1:0]  r_rspId;
  logic [WIDTH-1:0] r_rspSum;
  logic             r_rspOvf;

  logic             w_accept;
  logic             w_en;
  logic [N_REQ-1:0] w_grant;
  logic [ID_W-1:0]  w_grantIdx;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_sum;
  logic             w_ovf;
  logic             w_xfer;

  // The register can take a new result when empty or draining this cycle;
  // grants are also suppressed while reset is held.
  assign w_accept = !r_rspValid || rsp_ready;
  assign w_en     = w_accept && !rst;

  rr_arbiter #(
    .N_REQ(N_REQ),
    .ID_W (ID_W)
  ) u_arb (
    .clk      (clk),
    .rst      (rst),
    .req      (req_valid),
    .en       (w_en),
    .grant    (w_grant),
    .grant_idx(w_grantIdx)
  );

  assign req_ready = w_grant;
  assign w_xfer    = |(req_valid & w_grant);

  // AND-OR operand mux driven by the one-hot grant; zero when idle.
  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) begin
        w_a = w_a | req_a[i*WIDTH +: WIDTH];
        w_b = w_b | req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  ripple_carry_adder #(
    .WIDTH(WIDTH)
  ) u_adder (
    .a  (w_a),
    .b  (w_b),
    .cin(1'b0),
    .sum(w_sum)
  );

  // Overflow: like-signed operands producing a sum of the other sign.
  assign w_ovf = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]);

  // A new transfer overwrites the register even while it drains, which
  // keeps one result per cycle at full throughput.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rspValid <= 1'b0;
      r_rspId    <= '0;
      r_rspSum   <= '0;
      r_rspOvf   <= 1'b0;
    end else if (w_xfer) begin
      r_rspValid <= 1'b1;
      r_rspId    <= w_grantIdx;
      r_rspSum   <= w_sum;
      r_rspOvf   <= w_ovf;
    end else if (r_rspValid && rsp_ready) begin
      r_rspValid <= 1'b0;
    end
  end

  assign rsp_valid = r_rspValid;
  assign rsp_id    = r_rspId;
  assign rsp_sum   = r_rspSum;
  assign rsp_ovf   = r_rspOvf;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_adder_share_arbiter
// Directed, table-driven bench for adder_share_arbiter (N_REQ=4, WIDTH=32)
// with hand-written sequences for reset, round-robin, backpressure and
// pointer-skip behaviour.
// ---------------------------------------------------------------------------
module tb_adder_share_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 32;

  logic            clk;
  logic            rst;
  logic [NREQ-1:0] reqValid;
  logic [NREQ*W-1:0] reqA;
  logic [NREQ*W-1:0] reqB;
  logic [NREQ-1:0] reqReady;
  logic            rspValid;
  logic            rspReady;
  logic [1:0]      rspId;
  logic [W-1:0]    rspSum;
  logic            rspOvf;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [3:0]  valid;
    int          lane;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  expReady;
    logic        expValid;
    logic [1:0]  expId;
    logic [31:0] expSum;
    logic        expOvf;
  } vec_t;

  vec_t vecs[12];

  adder_share_arbiter #(
    .N_REQ(NREQ),
    .WIDTH(W),
    .ID_W (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(reqValid),
    .req_a    (reqA),
    .req_b    (reqB),
    .req_ready(reqReady),
    .rsp_valid(rspValid),
    .rsp_ready(rspReady),
    .rsp_id   (rspId),
    .rsp_sum  (rspSum),
    .rsp_ovf  (rspOvf)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One comparison: counts it and reports a mismatch.
  task automatic checkOutput(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Loads junk into every lane, then the real operands into one lane, so a
  // mux that selects the wrong lane produces a visibly wrong sum.
  task automatic applyStimulus(input int lane, input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < NREQ; i++) begin
      reqA[i*W +: W] = 32'hA5A5_0000 | i;
      reqB[i*W +: W] = 32'h0101_0100 | i;
    end
    reqA[lane*W +: W] = a;
    reqB[lane*W +: W] = b;
  endtask

  // One clock cycle: drive valid at the falling edge, check the grant
  // mid-cycle, then check the registered response just after the rise.
  task automatic runCycle(input string nm, input logic [3:0] valid, input logic [3:0] expReady,
                          input logic expValid, input logic [1:0] expId,
                          input logic [31:0] expSum, input logic expOvf);
    @(negedge clk);
    reqValid = valid;
    #1;
    checkOutput({nm, " req_ready"}, 64'(reqReady), 64'(expReady));
    @(posedge clk);
    #1;
    checkOutput({nm, " rsp_valid"}, 64'(rspValid), 64'(expValid));
    checkOutput({nm, " rsp_id"}, 64'(rspId), 64'(expId));
    checkOutput({nm, " rsp_sum"}, 64'(rspSum), 64'(expSum));
    checkOutput({nm, " rsp_ovf"}, 64'(rspOvf), 64'(expOvf));
  endtask

  initial begin
    // name, valid, lane, a, b, expReady, expValid, expId, expSum, expOvf
    vecs[0]  = '{"v0 5+7",        4'b0001, 0, 32'd5,        32'd7,        4'b0001, 1'b1, 2'd0, 32'd12,       1'b0};
    vecs[1]  = '{"v1 wrap",       4'b0010, 1, 32'hFFFFFFFF, 32'd1,        4'b0010, 1'b1, 2'd1, 32'd0,        1'b0};
    vecs[2]  = '{"v2 posovf",     4'b0100, 2, 32'h7FFFFFFF, 32'd1,        4'b0100, 1'b1, 2'd2, 32'h80000000, 1'b1};
    vecs[3]  = '{"v3 negovf",     4'b1000, 3, 32'h80000000, 32'h80000000, 4'b1000, 1'b1, 2'd3, 32'd0,        1'b1};
    vecs[4]  = '{"v4 neg",        4'b0001, 0, 32'hFFFFFFFE, 32'hFFFFFFFF, 4'b0001, 1'b1, 2'd0, 32'hFFFFFFFD, 1'b0};
    vecs[5]  = '{"v5 pick1of2",   4'b1010, 1, 32'd100,      32'd23,       4'b0010, 1'b1, 2'd1, 32'd123,      1'b0};
    vecs[6]  = '{"v6 req3",       4'b1000, 3, 32'd1,        32'd2,        4'b1000, 1'b1, 2'd3, 32'd3,        1'b0};
    vecs[7]  = '{"v7 ptr0",       4'b0110, 1, 32'h12345678, 32'h11111111, 4'b0010, 1'b1, 2'd1, 32'h23456789, 1'b0};
    vecs[8]  = '{"v8 ptr2",       4'b0110, 2, 32'h7FFFFFFF, 32'h7FFFFFFF, 4'b0100, 1'b1, 2'd2, 32'hFFFFFFFE, 1'b1};
    vecs[9]  = '{"v9 ptrwrap",    4'b0011, 0, 32'd0,        32'd0,        4'b0001, 1'b1, 2'd0, 32'd0,        1'b0};
    vecs[10] = '{"v10 idle",      4'b0000, 0, 32'd9,        32'd9,        4'b0000, 1'b0, 2'd0, 32'd0,        1'b0};
    vecs[11] = '{"v11 afteridle", 4'b0110, 1, 32'd3,        32'd4,        4'b0010, 1'b1, 2'd1, 32'd7,        1'b0};

    // Reset state, with requests already pending.
    rst      = 1'b1;
    rspReady = 1'b1;
    reqValid = 4'b1111;
    applyStimulus(0, 32'd0, 32'd0);
    #2;
    checkOutput("reset req_ready", 64'(reqReady), 64'd0);
    checkOutput("reset rsp_valid", 64'(rspValid), 64'd0);
    checkOutput("reset rsp_id", 64'(rspId), 64'd0);
    checkOutput("reset rsp_sum", 64'(rspSum), 64'd0);
    checkOutput("reset rsp_ovf", 64'(rspOvf), 64'd0);
    @(negedge clk);
    rst      = 1'b0;
    reqValid = 4'b0000;

    // Table of single-cycle transactions with the consumer always ready.
    for (int v = 0; v < 12; v++) begin
      applyStimulus(vecs[v].lane, vecs[v].a, vecs[v].b);
      runCycle(vecs[v].name, vecs[v].valid, vecs[v].expReady, vecs[v].expValid,
               vecs[v].expId, vecs[v].expSum, vecs[v].expOvf);
    end

    // Async reset between edges while a result is pending.
    @(negedge clk);
    reqValid = 4'b1111;
    #1;
    rst = 1'b1;
    #1;
    checkOutput("async rst rsp_valid", 64'(rspValid), 64'd0);
    checkOutput("async rst req_ready", 64'(reqReady), 64'd0);
    checkOutput("async rst rsp_sum", 64'(rspSum), 64'd0);
    checkOutput("async rst rsp_id", 64'(rspId), 64'd0);
    @(negedge clk);
    rst      = 1'b0;
    reqValid = 4'b0000;
    @(posedge clk);
    #1;

    // Round-robin with all requesters valid: lane i computes i*10 + 1.
    for (int i = 0; i < NREQ; i++) begin
      reqA[i*W +: W] = 32'(i * 10);
      reqB[i*W +: W] = 32'd1;
    end
    for (int k = 0; k < 6; k++) begin
      runCycle($sformatf("rr%0d", k), 4'b1111, 4'(1 << (k % 4)), 1'b1,
               2'(k % 4), 32'((k % 4) * 10 + 1), 1'b0);
    end

    // Backpressure: three stalled cycles hold the result, then grants
    // resume from requester 2.
    rspReady = 1'b0;
    for (int k = 0; k < 3; k++) begin
      runCycle($sformatf("stall%0d", k), 4'b1111, 4'b0000, 1'b1, 2'd1, 32'd11, 1'b0);
    end
    rspReady = 1'b1;
    runCycle("resume", 4'b1111, 4'b0100, 1'b1, 2'd2, 32'd21, 1'b0);

    // Pointer skip: pointer is 3, then 2, with only requester 1 asking;
    // an idle cycle must leave the pointer at 2.
    runCycle("skip from3", 4'b0010, 4'b0010, 1'b1, 2'd1, 32'd11, 1'b0);
    runCycle("skip from2", 4'b0010, 4'b0010, 1'b1, 2'd1, 32'd11, 1'b0);
    runCycle("skip idle", 4'b0000, 4'b0000, 1'b0, 2'd1, 32'd11, 1'b0);
    runCycle("skip after", 4'b0110, 4'b0100, 1'b1, 2'd2, 32'd21, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_share_arbiter.md
Name: adder_share_arbiter

Overview:
Shares one instance of the team's ripple-carry adder (WIDTH-bit, carry-in tied 0) among N_REQ requesters, such as the PC+4, branch-target and address-generation paths. A round-robin arbiter grants one requester per cycle. The operands are added, and the sum is captured in a single registered output stage with requester ID and signed-overflow flag. The output uses a valid/ready handshake so a stalled consumer back-pressures all requesters.

Parameters:
N_REQ, 4, number of requesters (2..8)
WIDTH, 32, operand and sum width
ID_W, 2, width of requester ID; must equal clog2(N_REQ)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  N_REQ  per-requester request; bit i belongs to requester i
req_a  in  N_REQ*WIDTH  operand A, flattened; requester i owns [i*WIDTH +: WIDTH]
req_b  in  N_REQ*WIDTH  operand B, flattened, same packing as req_a
req_ready  out  N_REQ  one-hot-or-zero grant; transfer when req_valid[i] & req_ready[i]
rsp_valid  out  1  result register holds a valid sum
rsp_ready  in  1  consumer accepts the result this cycle
rsp_id  out  ID_W  index of the requester that produced rsp_sum
rsp_sum  out  WIDTH  (a+b) mod 2^WIDTH
rsp_ovf  out  1  two's-complement overflow: a[MSB]==b[MSB] and sum[MSB]!=a[MSB]

Behaviour:
- Reset (async, rst=1): rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_ovf=0, rr pointer=0. req_ready is 0 while rst=1. Deassertion takes effect at the next rising edge.
- accept = !rsp_valid | rsp_ready (result register empty or draining this cycle).
- Grant (combinational): if accept=0, req_ready=0. Otherwise grant the first asserted req_valid at or after pointer p, searching p, p+1, ... N_REQ-1, 0, ... with wrap. Exactly one req_ready bit is high iff some req_valid is high. req_ready never depends on rsp_valid except through accept.
- Mux: the selected requester's a and b drive the shared adder. The adder is combinational and the same cycle's sum is used.
- On a clock edge with a transfer to requester g: rsp_valid<=1, rsp_id<=g, rsp_sum<=sum, rsp_ovf<=ovf, pointer<=(g+1) mod N_REQ.
- On a clock edge with rsp_valid & rsp_ready and no new transfer: rsp_valid<=0. rsp_id, rsp_sum and rsp_ovf hold their last values.
- Simultaneous drain and new grant in the same cycle: the new result overwrites the register and rsp_valid stays 1. This gives one result per cycle at full throughput.
- Latency: 1 cycle from transfer to rsp_valid.
- With no transfer, the pointer is unchanged, so an idle cycle does not cost a requester its turn.
- Requester rule: once req_valid[i] is raised, it and the operands stay stable until the transfer. The block does not check this.
- Stall: while rsp_valid=1 and rsp_ready=0, all req_ready=0 and the result register holds stable.
- Fairness: any requester holding valid is granted within N_REQ accepted grants.
- Arithmetic: carry-out is discarded and the sum wraps modulo 2^WIDTH. rsp_ovf is computed from the granted operands, not from the registered values.
- Reset mid-operation: a pending result is dropped. No partial transfer is ever reported.

Decomposition:
- Shared include file holds the clog2 function and default widths (ADDER_W=32, ADDER_NREQ=4). Every user of the block pulls ID_W from it.
- One sub-module, rr_arbiter (N_REQ, rst/clk, req, en, grant, grant_idx). It owns the pointer and the wrap search.
- The top level instantiates rr_arbiter, the operand mux, the existing adder module, and the output register.

Test Plan:
- Reset then single request: req_valid=4'b0001, a=5, b=7 -> req_ready=4'b0001 in the same cycle. Next cycle rsp_valid=1, rsp_id=0, rsp_sum=12, rsp_ovf=0.
- Round-robin: all four valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0,1 on consecutive cycles, rsp_valid held high every cycle after the first.
- Backpressure: rsp_ready=0 for 3 cycles with all requesters valid -> req_ready=0 and rsp_sum/rsp_id stable for 3 cycles. Grants resume in the cycle rsp_ready=1, continuing from the saved pointer.
- Wrap/overflow: a=32'hFFFFFFFF, b=1 -> rsp_sum=0, rsp_ovf=0. Then a=32'h7FFFFFFF, b=1 -> rsp_sum=32'h80000000, rsp_ovf=1.
- Pointer skip: pointer=2 with only req_valid=4'b0010 -> grant requester 1, pointer becomes 2. An idle cycle leaves the pointer unchanged.
- Async reset mid-stream: assert rst between clock edges while rsp_valid=1 -> rsp_valid drops to 0 immediately. After release, the first grant goes to requester 0.
